// File: rtl/piso_pkg.sv
// piso_pkg: shared definitions for the piso_tx serial transmitter.
//   ST_IDLE / ST_SHIFT / ST_PARITY : FSM state encoding
//   CNT_W(width)                   : bit-counter width for a given word width
package piso_pkg;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] ST_SHIFT  = 2'd1;
  localparam logic [ST_W-1:0] ST_PARITY = 2'd2;

  // Counter width; clamp to 1 so a degenerate width still yields a legal vector.
  function automatic int unsigned CNT_W(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_tx_if.sv
// piso_tx_if: load handshake plus serial link of the piso_tx transmitter.
//   load_valid / load_ready / parallel_in : word handshake (upstream -> transmitter)
//   serial_out / serial_valid             : serial bit stream (transmitter -> link)
//   frame_start / frame_done / busy       : frame status (transmitter -> observers)
// master = upstream/observer side, slave = the transmitter.
interface piso_tx_if #(
  parameter int unsigned WIDTH = 4
);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] parallel_in;
  logic             serial_out;
  logic             serial_valid;
  logic             frame_start;
  logic             frame_done;
  logic             busy;

  modport master (
    output load_valid, parallel_in,
    input  load_ready, serial_out, serial_valid, frame_start, frame_done, busy
  );

  modport slave (
    input  load_valid, parallel_in,
    output load_ready, serial_out, serial_valid, frame_start, frame_done, busy
  );

endinterface

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: synchronous-reset bit counter for one serial frame.
//   clk, reset : clock and synchronous active-high reset
//   clr_i      : restart at 0 (wins over en_i)
//   en_i       : advance by one; holds once WIDTH-1 is reached
//   cnt_o      : current count, CNT_W(WIDTH) bits
//   last_o     : count equals WIDTH-1
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr_i,
  input  logic                     en_i,
  output logic [CNT_W(WIDTH)-1:0]  cnt_o,
  output logic                     last_o
);

  localparam int unsigned    CW   = CNT_W(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: saturate at LAST so the count never runs past the frame.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == LAST);

endmodule

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter. Accepts a WIDTH-bit word on a
// valid/ready handshake and shifts it out one bit per clock.
//   clk, reset : clock and synchronous active-high reset
//   bus        : piso_tx_if.slave (load handshake, serial bit, frame status)
// Parameters: WIDTH (>= 2), MSB_FIRST (1: bit WIDTH-1 first, 0: bit 0 first).
// Optional macro PISO_PARITY_EN: append one even-parity bit to every frame.
// Status outputs are decoded from registered state only (no input-to-output paths).
module piso_tx
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  piso_tx_if.slave      bus
);

  localparam int unsigned CW = CNT_W(WIDTH);

  logic [ST_W-1:0]  state_q;
  logic [ST_W-1:0]  state_d;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_d;
  logic [CW-1:0]    cnt;
  logic             last;

  logic accept_c;
  logic ready_c;
  logic busy_c;
  logic valid_c;
  logic start_c;
  logic done_c;
  logic sout_c;
  logic sh_bit_c;

`ifdef PISO_PARITY_EN
  logic par_q;
  logic par_d;
`endif

  assign accept_c = bus.load_valid && ready_c;
  assign sh_bit_c = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];

  // Bit position within the current frame.
  piso_bit_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (accept_c),
    .en_i   (state_q == ST_SHIFT),
    .cnt_o  (cnt),
    .last_o (last)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; the final frame cycle either chains a new word or idles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (last) begin
`ifdef PISO_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = accept_c ? ST_SHIFT : ST_IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        state_d = accept_c ? ST_SHIFT : ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    ready_c = 1'b0;
    busy_c  = 1'b0;
    valid_c = 1'b0;
    start_c = 1'b0;
    done_c  = 1'b0;
    sout_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_c = 1'b1;
      end
      ST_SHIFT: begin
        busy_c  = 1'b1;
        valid_c = 1'b1;
        sout_c  = sh_bit_c;
        start_c = (cnt == '0);
`ifndef PISO_PARITY_EN
        done_c  = last;
        ready_c = last;
`endif
      end
`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        busy_c  = 1'b1;
        valid_c = 1'b1;
        sout_c  = par_q;
        done_c  = 1'b1;
        ready_c = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Shift register: load on accept, otherwise move the next bit into the output position.
  always_comb begin
    sh_d = sh_q;
    if (accept_c) begin
      sh_d = bus.parallel_in;
    end else if (state_q == ST_SHIFT) begin
      sh_d = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

`ifdef PISO_PARITY_EN
  // Parity is captured with the word since the shift register is emptied by the time it is sent.
  assign par_d = accept_c ? (^bus.parallel_in) : par_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  assign bus.load_ready   = ready_c;
  assign bus.busy         = busy_c;
  assign bus.serial_valid = valid_c;
  assign bus.frame_start  = start_c;
  assign bus.frame_done   = done_c;
  assign bus.serial_out   = sout_c;

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: drives an MSB-first and an LSB-first piso_tx with shared stimulus and
// compares every output each cycle against a frame-level model (list of bits to send).
module tb_piso_tx;

  localparam int unsigned W = 4;
`ifdef PISO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         valid;
  logic [W-1:0] pdata;

  int n_vec = 0;
  int n_err = 0;

  // Model: per DUT (0 = MSB first, 1 = LSB first) the bits of the frame in flight.
  bit act [2];
  int pos [2];
  bit fb  [2][W+1];

  logic [15:0] rec_m;
  logic [15:0] rec_l;

  always #5 clk = ~clk;

  piso_tx_if #(.WIDTH(W)) if_m ();
  piso_tx_if #(.WIDTH(W)) if_l ();

  assign if_m.load_valid  = valid;
  assign if_m.parallel_in = pdata;
  assign if_l.load_valid  = valid;
  assign if_l.parallel_in = pdata;

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .reset(rst), .bus(if_m));
  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .reset(rst), .bus(if_l));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit mdl_ready(input int k);
    return !act[k] || (pos[k] == FL - 1);
  endfunction

  task automatic load_frame(input int k, input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      fb[k][i] = (k == 0) ? w[W-1-i] : w[i];
    end
    fb[k][W] = ^w;
    act[k] = 1'b1;
    pos[k] = 0;
  endtask

  task automatic chk_dut(input int k, input string nm, input logic sv, input logic so,
                         input logic fs, input logic fd, input logic by, input logic rd);
    bit e_last;
    e_last = act[k] && (pos[k] == FL - 1);
    check({nm, "_valid"}, 32'(sv), 32'(act[k]));
    check({nm, "_busy"},  32'(by), 32'(act[k]));
    check({nm, "_out"},   32'(so), 32'(act[k] ? fb[k][pos[k]] : 1'b0));
    check({nm, "_start"}, 32'(fs), 32'(act[k] && pos[k] == 0));
    check({nm, "_done"},  32'(fd), 32'(e_last));
    check({nm, "_ready"}, 32'(rd), 32'(mdl_ready(k)));
  endtask

  // One clock: drive inputs, advance the model across the edge, then check outputs.
  task automatic step(input bit v, input logic [W-1:0] d, input bit r);
    bit acc [2];
    valid = v;
    pdata = d;
    rst   = r;
    for (int k = 0; k < 2; k++) acc[k] = v && mdl_ready(k);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        act[k] = 1'b0;
        pos[k] = 0;
      end else begin
        if (act[k]) begin
          pos[k]++;
          if (pos[k] == FL) act[k] = 1'b0;
        end
        if (acc[k]) load_frame(k, d);
      end
    end
    @(negedge clk);
    chk_dut(0, "msb", if_m.serial_valid, if_m.serial_out, if_m.frame_start,
            if_m.frame_done, if_m.busy, if_m.load_ready);
    chk_dut(1, "lsb", if_l.serial_valid, if_l.serial_out, if_l.frame_start,
            if_l.frame_done, if_l.busy, if_l.load_ready);
    if (if_m.serial_valid === 1'b1) rec_m = {rec_m[14:0], if_m.serial_out};
    if (if_l.serial_valid === 1'b1) rec_l = {rec_l[14:0], if_l.serial_out};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  initial begin
    act[0] = 1'b0; act[1] = 1'b0;
    pos[0] = 0;    pos[1] = 0;
    valid = 1'b0;
    pdata = '0;
    rst   = 1'b1;
    rec_m = '0;
    rec_l = '0;
    @(negedge clk);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    idle(2);

    // Single MSB-first word.
    rec_m = '0;
    step(1'b1, 4'b1011, 1'b0);
    idle(6);
`ifdef PISO_PARITY_EN
    check("t1_bits", 32'(rec_m), 32'h17);
`else
    check("t1_bits", 32'(rec_m), 32'hB);
`endif

    // Back-to-back frames with load_valid held high.
    rec_m = '0;
    step(1'b1, 4'hA, 1'b0);
    for (int i = 0; i < FL; i++) step(1'b1, 4'h5, 1'b0);
    idle(FL + 2);
`ifndef PISO_PARITY_EN
    check("t2_bits", 32'(rec_m), 32'hA5);
`endif

    // LSB-first word.
    rec_l = '0;
    step(1'b1, 4'b0001, 1'b0);
    idle(6);
`ifdef PISO_PARITY_EN
    check("t3_bits", 32'(rec_l), 32'h11);
`else
    check("t3_bits", 32'(rec_l), 32'h8);
`endif

    // Reset during the second bit of 4'hF.
    step(1'b1, 4'hF, 1'b0);
    step(1'b0, 4'hF, 1'b0);
    step(1'b0, 4'hF, 1'b1);
    check("t4_busy", 32'(if_m.busy), 32'h0);
    idle(3);

`ifdef PISO_PARITY_EN
    // Even parity appended.
    rec_m = '0;
    step(1'b1, 4'b0111, 1'b0);
    idle(6);
    check("t5a_bits", 32'(rec_m), 32'h0F);
    rec_m = '0;
    step(1'b1, 4'b0011, 1'b0);
    idle(6);
    check("t5b_bits", 32'(rec_m), 32'h06);
`endif

    // Mid-frame load_valid pulse and parallel_in change are ignored.
    rec_m = '0;
    step(1'b1, 4'hC, 1'b0);
    step(1'b0, 4'h0, 1'b0);
    step(1'b1, 4'h0, 1'b0);
    idle(6);
`ifdef PISO_PARITY_EN
    check("t6_bits", 32'(rec_m), 32'h18);
`else
    check("t6_bits", 32'(rec_m), 32'hC);
`endif

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 2) != 0), W'($urandom), ($urandom_range(0, 63) == 0));
    end
    idle(FL + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
